// File: rtl/uart_rx_ctrl.sv
// UART receiver control wrapper: idle-gated config apply, edge-to-push byte capture into an
// FWFT FIFO, and saturating parity/stop/overflow counters.
module uart_rx_ctrl #(
  parameter int          DATA_W       = 8,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          CNT_W        = 8,
  parameter logic [5:0]  DEF_PRESCALE = 6'd8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [5:0]        cfg_prescale,
  input  logic              cfg_par_en,
  input  logic              cfg_par_typ,
  input  logic              rx_busy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_data_valid,
  input  logic              rx_par_error,
  input  logic              rx_stop_error,
  input  logic              rd_en,
  input  logic              cnt_clr,
  output logic [5:0]        Prescale,
  output logic              PAR_EN,
  output logic              PAR_TYP,
  output logic              rx_hold,
  output logic              cfg_pending,
  output logic              cfg_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  stop_err_cnt,
  output logic [CNT_W-1:0]  ovf_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ACTIVE, PEND, APPLY} state_t;

  state_t     state;
  logic [5:0] sh_pre;
  logic       sh_en, sh_typ;
  logic       cfg_legal, cfg_take;

  assign cfg_legal = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
  assign cfg_take  = cfg_wr && cfg_legal;

  // Shadow lands on the receiver only when leaving APPLY, so a frame in flight never sees a change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ACTIVE;
      sh_pre   <= DEF_PRESCALE;
      sh_en    <= 1'b1;
      sh_typ   <= 1'b0;
      Prescale <= DEF_PRESCALE;
      PAR_EN   <= 1'b1;
      PAR_TYP  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !cfg_legal;
      if (cfg_take) begin
        sh_pre <= cfg_prescale;
        sh_en  <= cfg_par_en;
        sh_typ <= cfg_par_typ;
      end
      case (state)
        ACTIVE: if (cfg_take) state <= PEND;
        PEND:   if (!rx_busy) state <= APPLY;
        APPLY: begin
          Prescale <= sh_pre;
          PAR_EN   <= sh_en;
          PAR_TYP  <= sh_typ;
          state    <= cfg_take ? PEND : ACTIVE;
        end
        default: state <= ACTIVE;
      endcase
    end
  end

  assign rx_hold     = (state != ACTIVE);
  assign cfg_pending = (state != ACTIVE);

  logic dv_q, pe_q, se_q;
  logic push, pe_rise, se_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
    end else begin
      dv_q <= rx_data_valid;
      pe_q <= rx_par_error;
      se_q <= rx_stop_error;
    end
  end

  assign push    = rx_data_valid && !dv_q;
  assign pe_rise = rx_par_error && !pe_q;
  assign se_rise = rx_stop_error && !se_q;

  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW:0] wptr, rptr;
  logic        pop, wr_ok, ovf;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = rd_en && !fifo_empty;
  assign wr_ok      = push && (!fifo_full || pop);
  assign ovf        = push && fifo_full && !pop;
  assign rd_data    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        mem[wptr[AW-1:0]] <= rx_data;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
      ovf_cnt      <= '0;
    end else if (cnt_clr) begin
      par_err_cnt  <= '0;
      stop_err_cnt <= '0;
      ovf_cnt      <= '0;
    end else begin
      par_err_cnt  <= sat_inc(par_err_cnt, pe_rise);
      stop_err_cnt <= sat_inc(stop_err_cnt, se_rise);
      ovf_cnt      <= sat_inc(ovf_cnt, ovf);
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: cycle vector table for capture/config, hand sequences for
// overflow, counter saturation and pending-config corner cases.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [5:0] cfg_prescale = 6'd8;
  logic       cfg_par_en = 1'b1, cfg_par_typ = 1'b0;
  logic       rx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0, rx_par_error = 1'b0, rx_stop_error = 1'b0;
  logic       rd_en = 1'b0, cnt_clr = 1'b0;
  logic [5:0] Prescale;
  logic       PAR_EN, PAR_TYP, rx_hold, cfg_pending, cfg_err;
  logic [7:0] rd_data;
  logic       fifo_empty, fifo_full;
  logic [7:0] par_err_cnt, stop_err_cnt, ovf_cnt;

  int checks = 0;
  int failures = 0;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale),
    .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .rx_busy(rx_busy),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_par_error(rx_par_error),
    .rx_stop_error(rx_stop_error), .rd_en(rd_en), .cnt_clr(cnt_clr),
    .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .rx_hold(rx_hold),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .rd_data(rd_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .par_err_cnt(par_err_cnt),
    .stop_err_cnt(stop_err_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [5:0] pre;
    logic       busy;
    logic [7:0] data;
    logic       dv;
    logic       rd;
    logic [5:0] e_pre;
    logic       e_hold;
    logic       e_err;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic rd);
    rx_data = b; rx_data_valid = 1'b1; rd_en = rd;
    tick();
    rx_data_valid = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, rd_data, exp);
    chk({name, "_empty"}, fifo_empty, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    //        wr  pre    busy data   dv  rd   e_pre  hold err empty full e_rd
    vecs[0]  = '{0, 6'd8,  0, 8'h00, 0, 0,  6'd8,  0, 0, 1, 0, 8'h00};
    vecs[1]  = '{0, 6'd8,  0, 8'hA5, 1, 0,  6'd8,  0, 0, 0, 0, 8'hA5};
    vecs[2]  = '{0, 6'd8,  0, 8'hA5, 1, 0,  6'd8,  0, 0, 0, 0, 8'hA5};
    vecs[3]  = '{0, 6'd8,  0, 8'hA5, 1, 0,  6'd8,  0, 0, 0, 0, 8'hA5};
    vecs[4]  = '{0, 6'd8,  0, 8'hA5, 1, 0,  6'd8,  0, 0, 0, 0, 8'hA5};
    vecs[5]  = '{0, 6'd8,  0, 8'hA5, 1, 0,  6'd8,  0, 0, 0, 0, 8'hA5};
    vecs[6]  = '{0, 6'd8,  0, 8'h00, 0, 1,  6'd8,  0, 0, 1, 0, 8'h00};
    vecs[7]  = '{1, 6'd12, 0, 8'h00, 0, 0,  6'd8,  0, 1, 1, 0, 8'h00};
    vecs[8]  = '{0, 6'd8,  0, 8'h00, 0, 0,  6'd8,  0, 0, 1, 0, 8'h00};
    vecs[9]  = '{1, 6'd16, 1, 8'h00, 0, 0,  6'd8,  1, 0, 1, 0, 8'h00};
    vecs[10] = '{0, 6'd8,  1, 8'h00, 0, 0,  6'd8,  1, 0, 1, 0, 8'h00};
    vecs[11] = '{0, 6'd8,  0, 8'h00, 0, 0,  6'd8,  1, 0, 1, 0, 8'h00};
    vecs[12] = '{0, 6'd8,  0, 8'h00, 0, 0,  6'd16, 0, 0, 1, 0, 8'h00};

    // Reset state
    #12;
    chk("rst_prescale", Prescale, 6'd8);
    chk("rst_par_en", PAR_EN, 1'b1);
    chk("rst_par_typ", PAR_TYP, 1'b0);
    chk("rst_hold", rx_hold, 1'b0);
    chk("rst_pending", cfg_pending, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_cnts", {par_err_cnt, stop_err_cnt, ovf_cnt}, 24'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Capture, illegal config, pending config across a busy frame
    for (int i = 0; i < 13; i++) begin
      cfg_wr = vecs[i].wr; cfg_prescale = vecs[i].pre; rx_busy = vecs[i].busy;
      rx_data = vecs[i].data; rx_data_valid = vecs[i].dv; rd_en = vecs[i].rd;
      tick();
      chk($sformatf("v%0d_prescale", i), Prescale, vecs[i].e_pre);
      chk($sformatf("v%0d_hold", i), rx_hold, vecs[i].e_hold);
      chk($sformatf("v%0d_pending", i), cfg_pending, vecs[i].e_hold);
      chk($sformatf("v%0d_cfg_err", i), cfg_err, vecs[i].e_err);
      chk($sformatf("v%0d_empty", i), fifo_empty, vecs[i].e_empty);
      chk($sformatf("v%0d_full", i), fifo_full, vecs[i].e_full);
      if (!vecs[i].e_empty) chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_rd);
    end
    cfg_wr = 1'b0; rx_busy = 1'b0; rx_data_valid = 1'b0; rd_en = 1'b0;

    // Overflow: five bytes into four entries
    for (int b = 1; b <= 5; b++) push_byte(8'(b), 1'b0);
    chk("ovf_full", fifo_full, 1'b1);
    chk("ovf_cnt", ovf_cnt, 8'd1);
    // Push and pop together while full: both happen, still full, no overflow
    push_byte(8'h06, 1'b1);
    chk("pp_full", fifo_full, 1'b1);
    chk("pp_ovf_cnt", ovf_cnt, 8'd1);
    pop_chk("rd0", 8'h02);
    pop_chk("rd1", 8'h03);
    pop_chk("rd2", 8'h04);
    pop_chk("rd3", 8'h06);
    chk("drain_empty", fifo_empty, 1'b1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rd_empty_ignored", fifo_empty, 1'b1);
    chk("rd_empty_full", fifo_full, 1'b0);

    // Counter saturation and clear priority
    for (int k = 0; k < 300; k++) begin
      rx_par_error = 1'b1; tick();
      rx_par_error = 1'b0; tick();
    end
    chk("par_sat", par_err_cnt, 8'd255);
    for (int k = 0; k < 3; k++) begin
      rx_stop_error = 1'b1; tick(); tick();
      rx_stop_error = 1'b0; tick();
    end
    chk("stop_cnt", stop_err_cnt, 8'd3);
    rx_par_error = 1'b1; cnt_clr = 1'b1; tick();
    chk("clr_par", par_err_cnt, 8'd0);
    chk("clr_stop", stop_err_cnt, 8'd0);
    chk("clr_ovf", ovf_cnt, 8'd0);
    cnt_clr = 1'b0; tick();
    chk("clr_level_no_edge", par_err_cnt, 8'd0);
    rx_par_error = 1'b0; tick();

    // Two writes while pending: last one wins
    rx_busy = 1'b1;
    cfg_wr = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b0; tick();
    cfg_prescale = 6'd32; cfg_par_en = 1'b0; cfg_par_typ = 1'b1; tick();
    cfg_wr = 1'b0;
    chk("pend_hold", rx_hold, 1'b1);
    chk("pend_prescale", Prescale, 6'd16);
    rx_busy = 1'b0; tick(); tick();
    chk("lww_prescale", Prescale, 6'd32);
    chk("lww_par_en", PAR_EN, 1'b0);
    chk("lww_par_typ", PAR_TYP, 1'b1);
    chk("lww_hold", rx_hold, 1'b0);

    // Async reset while pending
    rx_busy = 1'b1; cfg_wr = 1'b1; cfg_prescale = 6'd16; tick();
    cfg_wr = 1'b0;
    chk("pend2_pending", cfg_pending, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_prescale", Prescale, 6'd8);
    chk("arst_par_en", PAR_EN, 1'b1);
    chk("arst_par_typ", PAR_TYP, 1'b0);
    chk("arst_hold", rx_hold, 1'b0);
    chk("arst_pending", cfg_pending, 1'b0);
    @(negedge clk);
    rst = 1'b1; rx_busy = 1'b0;
    tick(); tick(); tick();
    chk("arst_stays_idle", rx_hold, 1'b0);
    chk("arst_prescale_kept", Prescale, 6'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim ran past 200000 expected finish earlier");
    $fatal(1);
  end
endmodule
